// File: rtl/mem_map_pkg.sv
// Shared definitions for the memory responder slice.
// Holds the MMIO register addresses, reset constants and the loader
// state encoding used by mem_responder and mmio_timer.
package mem_map_pkg;

    localparam logic [31:0] ADDR_GPIO_OUT  = 32'h0000_1000;
    localparam logic [31:0] ADDR_TIMER     = 32'h0000_1004;
    localparam logic [31:0] ADDR_TIMER_CMP = 32'h0000_1008;
    localparam logic [31:0] ADDR_STATUS    = 32'h0000_100C;

    localparam logic [31:0] TIMER_CMP_RST  = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mmio_timer.sv
// Free-running timer with compare register and sticky match flag.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   run            : 1 while the responder is in RUN; timer counts and matches only then
//   timer_we       : CPU write to TIMER this cycle (loads wr_data, no increment)
//   cmp_we         : CPU write to TIMER_CMP this cycle
//   status_we      : CPU write to STATUS this cycle (wr_data[0]=1 clears the flag)
//   wr_data        : CPU store data
//   timer, cmp     : current TIMER / TIMER_CMP contents
//   match_flag     : sticky compare-match flag (STATUS bit0)
module mmio_timer
    import mem_map_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        timer_we,
    input  logic        cmp_we,
    input  logic        status_we,
    input  logic [31:0] wr_data,
    output logic [31:0] timer,
    output logic [31:0] cmp,
    output logic        match_flag
);

    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        status_q, status_d;
    logic        match_set;
    logic        match_clr;

    always_comb begin
        timer_d = timer_q;
        if (timer_we) begin
            timer_d = wr_data;
        end else if (run) begin
            timer_d = timer_q + 32'd1;
        end

        cmp_d = cmp_we ? wr_data : cmp_q;

        // Match is judged on the registered values of this cycle; a set in
        // the same cycle as a write-1-to-clear keeps the flag set.
        match_set = run && (timer_q == cmp_q);
        match_clr = status_we && wr_data[0];
        status_d  = match_set | (status_q & ~match_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q  <= '0;
            cmp_q    <= TIMER_CMP_RST;
            status_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            cmp_q    <= cmp_d;
            status_q <= status_d;
        end
    end

    assign timer      = timer_q;
    assign cmp        = cmp_q;
    assign match_flag = status_q;

endmodule

// File: rtl/mem_responder.sv
// Memory/MMIO responder for a multicycle CPU with a boot-time RAM loader.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   LOAD  | CPU held in reset, loader words written to RAM[ptr]
//   RUN   | CPU running, loader ignored, left only by reset
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   Mem_Addr, Mem_WrData  : CPU byte address and store data
//   MemWrite              : CPU store strobe (ignored in LOAD)
//   Mem_RdData            : combinational read data for Mem_Addr
//   Load_Valid/Data/Last  : loader word stream
//   Load_Ready            : 1 while loader words are accepted
//   Cpu_Hold              : holds the CPU in reset while 1
//   Gpio_Out              : GPIO_OUT register
//   Timer_Irq             : sticky timer compare-match flag
//
// RAM occupies word addresses 0..DEPTH-1 and takes priority over the MMIO
// registers if DEPTH is large enough to overlap them.
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter bit BOOT_LOAD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Mem_Addr,
    input  logic [31:0] Mem_WrData,
    input  logic        MemWrite,
    output logic [31:0] Mem_RdData,
    input  logic        Load_Valid,
    input  logic [31:0] Load_Data,
    input  logic        Load_Last,
    output logic        Load_Ready,
    output logic        Cpu_Hold,
    output logic [31:0] Gpio_Out,
    output logic        Timer_Irq
);

    localparam int AW = $clog2(DEPTH);

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [31:0]     gpio_q, gpio_d;
    logic [31:0]     ram_q [DEPTH];

    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [31:0]     ram_wdata;

    logic [31:0]     word_addr;
    logic [AW-1:0]   cpu_ram_idx;
    logic            ram_hit;
    logic            sel_gpio, sel_timer, sel_cmp, sel_status;
    logic            run;
    logic            cpu_we;
    logic [31:0]     timer_val, cmp_val;
    logic            match_flag;
    logic            unused_addr_lsbs;

    // Byte offset within a word carries no meaning here.
    assign unused_addr_lsbs = ^Mem_Addr[1:0];

    assign word_addr   = {Mem_Addr[31:2], 2'b00};
    assign cpu_ram_idx = Mem_Addr[AW+1:2];
    assign ram_hit     = (Mem_Addr[31:AW+2] == '0);
    assign sel_gpio    = !ram_hit && (word_addr == ADDR_GPIO_OUT);
    assign sel_timer   = !ram_hit && (word_addr == ADDR_TIMER);
    assign sel_cmp     = !ram_hit && (word_addr == ADDR_TIMER_CMP);
    assign sel_status  = !ram_hit && (word_addr == ADDR_STATUS);

    assign run    = (state_q == ST_RUN);
    assign cpu_we = MemWrite && run;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ram_we    = 1'b0;
        ram_waddr = cpu_ram_idx;
        ram_wdata = Mem_WrData;
        case (state_q)
            ST_LOAD: begin
                if (Load_Valid) begin
                    ram_we    = 1'b1;
                    ram_waddr = ptr_q;
                    ram_wdata = Load_Data;
                    // The last RAM slot ends the load even without Last so
                    // ptr never wraps onto already-loaded words.
                    if (Load_Last || (ptr_q == AW'(DEPTH - 1))) begin
                        state_d = ST_RUN;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (MemWrite && ram_hit) begin
                    ram_we = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        gpio_d = (cpu_we && sel_gpio) ? Mem_WrData : gpio_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT_LOAD ? ST_LOAD : ST_RUN;
            ptr_q   <= '0;
            gpio_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gpio_q  <= gpio_d;
        end
    end

    // RAM has no reset; writes are suppressed while reset is asserted so a
    // restarted load sees exactly the words written before the reset.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    mmio_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .timer_we   (cpu_we && sel_timer),
        .cmp_we     (cpu_we && sel_cmp),
        .status_we  (cpu_we && sel_status),
        .wr_data    (Mem_WrData),
        .timer      (timer_val),
        .cmp        (cmp_val),
        .match_flag (match_flag)
    );

    always_comb begin
        Mem_RdData = '0;
        if (ram_hit) begin
            Mem_RdData = ram_q[cpu_ram_idx];
        end else if (sel_gpio) begin
            Mem_RdData = gpio_q;
        end else if (sel_timer) begin
            Mem_RdData = timer_val;
        end else if (sel_cmp) begin
            Mem_RdData = cmp_val;
        end else if (sel_status) begin
            Mem_RdData = {31'b0, match_flag};
        end
    end

    assign Cpu_Hold   = (state_q == ST_LOAD);
    assign Load_Ready = (state_q == ST_LOAD);
    assign Gpio_Out   = gpio_q;
    assign Timer_Irq  = match_flag;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int D = 64;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (DEPTH=64, boot load)
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0, ld = '0;
    logic        mw = 1'b0, lv = 1'b0, ll = 1'b0;
    logic [31:0] rd, gpio;
    logic        ready, hold, irq;

    // small DUT for the overflow case (DEPTH=4)
    logic        rst4 = 1'b1;
    logic [31:0] addr4 = '0, ld4 = '0;
    logic        lv4 = 1'b0, ll4 = 1'b0;
    logic [31:0] rd4, gpio4;
    logic        ready4, hold4, irq4;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mem_responder #(.DEPTH(D), .BOOT_LOAD(1'b1)) dut (
        .clk(clk), .reset(rst), .Mem_Addr(addr), .Mem_WrData(wdata), .MemWrite(mw),
        .Mem_RdData(rd), .Load_Valid(lv), .Load_Data(ld), .Load_Last(ll),
        .Load_Ready(ready), .Cpu_Hold(hold), .Gpio_Out(gpio), .Timer_Irq(irq)
    );

    mem_responder #(.DEPTH(4), .BOOT_LOAD(1'b1)) dut4 (
        .clk(clk), .reset(rst4), .Mem_Addr(addr4), .Mem_WrData(32'h0), .MemWrite(1'b0),
        .Mem_RdData(rd4), .Load_Valid(lv4), .Load_Data(ld4), .Load_Last(ll4),
        .Load_Ready(ready4), .Cpu_Hold(hold4), .Gpio_Out(gpio4), .Timer_Irq(irq4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the main DUT ----------------
    logic [31:0] m_ram [int];
    logic [31:0] m_gpio, m_timer, m_cmp;
    bit          m_stat, m_load;
    int          m_ptr;

    function automatic bit m_read(input logic [31:0] a, output logic [31:0] v);
        int unsigned w = a >> 2;
        v = '0;
        if (w < D) begin
            if (!m_ram.exists(int'(w))) return 1'b0;
            v = m_ram[int'(w)];
        end else if (w == 32'h400) v = m_gpio;
        else if (w == 32'h401) v = m_timer;
        else if (w == 32'h402) v = m_cmp;
        else if (w == 32'h403) v = {31'b0, m_stat};
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        logic [31:0] nt;
        bit          match, clr;
        int unsigned w;
        if (rst) begin
            m_gpio = 0; m_timer = 0; m_cmp = 32'hFFFF_FFFF; m_stat = 0;
            m_ptr = 0; m_load = 1;
        end else if (m_load) begin
            if (lv) begin
                m_ram[m_ptr] = ld;
                if (ll || m_ptr == D - 1) m_load = 0;
                else m_ptr++;
            end
        end else begin
            match = (m_timer == m_cmp);
            nt    = m_timer + 1;
            clr   = 0;
            w     = addr >> 2;
            if (mw) begin
                if (w < D) m_ram[int'(w)] = wdata;
                else if (w == 32'h400) m_gpio = wdata;
                else if (w == 32'h401) nt = wdata;
                else if (w == 32'h402) m_cmp = wdata;
                else if (w == 32'h403) clr = wdata[0];
            end
            m_timer = nt;
            m_stat  = match | (m_stat & !clr);
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        logic [31:0] ev;
        if (chk_en) begin
            if (m_read(addr, ev)) chk("model_rd", rd, ev);
            chk("model_hold",  {31'b0, hold},  {31'b0, m_load});
            chk("model_ready", {31'b0, ready}, {31'b0, m_load});
            chk("model_gpio",  gpio, m_gpio);
            chk("model_irq",   {31'b0, irq},   {31'b0, m_stat});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mw = 1; addr = a; wdata = d;
        tick();
        mw = 0;
    endtask

    initial begin
        logic [31:0] v;
        int unsigned r;

        tick();
        chk_en = 1;
        tick();

        // reset state
        addr = 32'h1008; #1 chk("rst_cmp", rd, 32'hFFFF_FFFF);
        addr = 32'h1004; #1 chk("rst_timer", rd, 32'h0);
        addr = 32'h100C; #1 chk("rst_status", rd, 32'h0);
        chk("rst_hold", {31'b0, hold}, 32'h1);
        chk("rst_ready", {31'b0, ready}, 32'h1);
        chk("rst_gpio", gpio, 32'h0);

        // overflow on the DEPTH=4 instance: 4 words without Last
        rst4 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            lv4 = 1; ld4 = 32'hA0 + 32'(i);
            #1 chk("ovf_hold_during", {31'b0, hold4}, 32'h1);
        end
        tick();
        ld4 = 32'hEE;
        #1 chk("ovf_hold_after", {31'b0, hold4}, 32'h0);
        chk("ovf_ready_after", {31'b0, ready4}, 32'h0);
        tick();
        lv4 = 0;
        for (int i = 0; i < 4; i++) begin
            addr4 = 32'(i * 4);
            #1 chk("ovf_ram", rd4, 32'hA0 + 32'(i));
        end

        // load 0x11,0x22,0x33; a CPU store during LOAD is dropped
        rst = 0;
        mw = 1; addr = 32'h1000; wdata = 32'h5;
        tick();
        mw = 0; addr = 32'h1004; lv = 1; ld = 32'h11;
        #1 chk("load_gpio_ignored", gpio, 32'h0);
        tick();
        ld = 32'h22;
        #1 chk("load_timer_held", rd, 32'h0);
        tick();
        ld = 32'h33; ll = 1;
        #1 chk("load_hold_last", {31'b0, hold}, 32'h1);
        tick();
        ld = 32'hBAD; ll = 0;      // loader ignored in RUN
        #1 chk("load_hold_fall", {31'b0, hold}, 32'h0);
        chk("load_ready_fall", {31'b0, ready}, 32'h0);
        tick();
        lv = 0;
        for (int i = 0; i < 3; i++) begin
            addr = 32'(i * 4);
            #1 chk("load_ram", rd, 32'h11 * 32'(i + 1));
        end
        addr = 32'hC; #1 chk("load_ram3_free", 32'(m_ram.exists(3)), 32'h0);

        // CPU write / read-during-write
        wr(32'h10, 32'h1234_5678);
        mw = 1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
        #1 chk("wr_old", rd, 32'h1234_5678);
        tick();
        mw = 0;
        #1 chk("wr_new", rd, 32'hDEAD_BEEF);
        addr = 32'h2000; #1 chk("unmapped_rd", rd, 32'h0);
        addr = 32'h13;   #1 chk("lsb_ignored", rd, 32'hDEAD_BEEF);

        // timer wrap and irq
        wr(32'h100C, 32'h1);
        wr(32'h1008, 32'h0);
        wr(32'h1004, 32'hFFFF_FFFE);
        addr = 32'h1004;
        #1 chk("wrap_t0", rd, 32'hFFFF_FFFE);
        tick(); chk("wrap_t1", rd, 32'hFFFF_FFFF);
        tick(); chk("wrap_t2", rd, 32'h0);
        chk("wrap_irq_low", {31'b0, irq}, 32'h0);
        tick(); chk("wrap_irq_high", {31'b0, irq}, 32'h1);
        chk("wrap_t3", rd, 32'h1);

        // set wins over clear
        wr(32'h1008, 32'h100);
        wr(32'h1004, 32'hFF);
        tick();                    // TIMER now 0x100 == CMP
        wr(32'h100C, 32'h1);
        addr = 32'h100C;
        #1 chk("setwins_status", rd, 32'h1);
        chk("setwins_irq", {31'b0, irq}, 32'h1);
        wr(32'h100C, 32'h1);
        addr = 32'h100C;
        #1 chk("clear_status", rd, 32'h0);
        chk("clear_irq", {31'b0, irq}, 32'h0);

        // randomized traffic against the model
        repeat (600) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: addr = $urandom_range(0, D - 1) * 4 + $urandom_range(0, 3);
                4: addr = 32'h1000;
                5: addr = 32'h1004;
                6: addr = 32'h1008;
                7: addr = 32'h100C;
                8: addr = $urandom | 32'h0010_0000;
                default: addr = 32'h1010;
            endcase
            wdata = (r == 5 || r == 6) ? 32'(m_timer + $urandom_range(0, 8)) : $urandom;
            mw = 1'($urandom_range(0, 1));
            lv = 1'($urandom_range(0, 1));
            ld = $urandom;
            ll = 1'($urandom_range(0, 1));
            tick();
        end
        mw = 0; lv = 0; ll = 0;

        // reset mid-load
        wr(32'h1000, 32'hCAFE);
        rst = 1;
        tick();
        rst = 0;
        #1 chk("rst_gpio_cleared", gpio, 32'h0);
        lv = 1; ld = 32'hA1;
        tick();
        ld = 32'hA2;
        tick();
        lv = 0; rst = 1;
        tick();
        rst = 0; lv = 1; ld = 32'h99; ll = 1;
        tick();
        lv = 0; ll = 0;
        addr = 32'h0; #1 chk("midload_ram0", rd, 32'h99);
        addr = 32'h4; #1 chk("midload_ram1", rd, 32'hA2);
        chk("midload_gpio", gpio, 32'h0);
        chk("midload_hold", {31'b0, hold}, 32'h0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: RAM size in 32-bit words, power of two.
REQ-002 SHALL have parameter BOOT_LOAD, default 1: 1 holds the CPU while the loader fills RAM; 0 runs immediately.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port Mem_Addr, input, 32: CPU byte address, read and write.
REQ-006 SHALL have port Mem_WrData, input, 32: CPU store data.
REQ-007 SHALL have port MemWrite, input, 1: CPU store strobe, one word per asserted cycle.
REQ-008 SHALL have port Mem_RdData, output, 32: read data for Mem_Addr.
REQ-009 SHALL have port Load_Valid, input, 1: loader word valid.
REQ-010 SHALL have port Load_Data, input, 32: loader word.
REQ-011 SHALL have port Load_Last, input, 1: marks the final loader word.
REQ-012 SHALL have port Load_Ready, output, 1: responder accepts a loader word.
REQ-013 SHALL have port Cpu_Hold, output, 1: the CPU's reset is held while this is 1.
REQ-014 SHALL have port Gpio_Out, output, 32: GPIO register contents.
REQ-015 SHALL have port Timer_Irq, output, 1: the sticky compare-match flag.

Function
REQ-016 SHALL decode the address map as: RAM at 0x0000_0000 to DEPTH*4-1; GPIO_OUT at 0x1000 (RW); TIMER at 0x1004 (RW); TIMER_CMP at 0x1008 (RW); STATUS at 0x100C (bit0 match, write-1-to-clear).
REQ-017 SHALL ignore Mem_Addr[1:0] and address words only.
REQ-018 SHALL return 0 for unmapped reads and drop unmapped writes.
REQ-019 SHALL drive Mem_RdData combinationally from Mem_Addr with zero-cycle latency, which the multicycle CPU's fetch and memory-read states require.
REQ-020 SHALL commit writes at the clock edge.
REQ-021 SHALL, for a read of an address in its write cycle, return the old data and show the new data from the next cycle.
REQ-022 SHALL implement the FSM states LOAD and RUN.
REQ-023 SHALL drive Cpu_Hold=1 and Load_Ready=1 in LOAD, and Cpu_Hold=0 and Load_Ready=0 in RUN.
REQ-024 SHALL, in LOAD, write Load_Data to RAM[ptr] and increment ptr on each cycle with Load_Valid=1.
REQ-025 SHALL move LOAD to RUN on an accepted word with Load_Last=1, or on an accepted word at ptr=DEPTH-1; ptr SHALL never wrap.
REQ-026 SHALL ignore CPU writes in LOAD, while reads stay served.
REQ-027 SHALL ignore the loader in RUN; RUN is left only by reset.
REQ-028 SHALL, in RUN, increment TIMER by 1 per cycle, wrapping from 0xFFFF_FFFF to 0.
REQ-029 SHALL, on a CPU write to TIMER, load the written value in that cycle with no increment.
REQ-030 SHALL hold TIMER in LOAD.
REQ-031 SHALL set STATUS.bit0 on any cycle where TIMER==TIMER_CMP in RUN; bit0 stays set until cleared.
REQ-032 SHALL clear bit0 on a STATUS write with bit0=1; if set and clear occur in the same cycle, set wins.
REQ-033 SHALL read STATUS bits [31:1] as 0.
REQ-034 SHALL drive Timer_Irq equal to STATUS.bit0.

Reset
REQ-035 SHALL, on reset, set GPIO_OUT=0, TIMER=0, TIMER_CMP=0xFFFF_FFFF, STATUS=0 and ptr=0.
REQ-036 SHALL, on reset, set the state to LOAD if BOOT_LOAD=1, else RUN.
REQ-037 SHALL leave RAM contents unaffected by reset.
REQ-038 SHALL, on reset asserted mid-load, restart loading at ptr=0 from the next cycle; words already written stay in RAM.

Structure
REQ-039 SHALL place the address constants (GPIO_OUT, TIMER, TIMER_CMP, STATUS) and the LOAD/RUN state encoding in shared package mem_map_pkg.
REQ-040 SHALL place TIMER, TIMER_CMP, STATUS and the match logic in one sub-module, mmio_timer.
REQ-041 SHALL keep the RAM array, the decode logic and the loader FSM in mem_responder.

Verification
REQ-042 SHALL verify load: BOOT_LOAD=1, reset, then 3 words 0x11,0x22,0x33 with Last on the third -> RAM[0..2] hold them, Cpu_Hold falls the cycle after the third word, Load_Ready=0 afterwards.
REQ-043 SHALL verify load overflow: DEPTH=4, 4 words without Last -> RUN after the 4th word; a 5th Load_Valid writes nothing and RAM[0] is unchanged.
REQ-044 SHALL verify CPU access: in RUN, write 0xDEADBEEF to 0x10 -> Mem_RdData at 0x10 shows the old value in the write cycle and 0xDEADBEEF in the next; a read of 0x2000 gives 0.
REQ-045 SHALL verify timer wrap: write TIMER=0xFFFF_FFFE and CMP=0 -> TIMER reads 0 two cycles later, and Timer_Irq rises the cycle after TIMER reaches 0.
REQ-046 SHALL verify set-wins clear: write STATUS=1 in the same cycle as a new match -> bit0 stays 1; a clear one cycle later with no match gives 0.
REQ-047 SHALL verify reset mid-load: reset after 2 words, then load 1 word 0x99 with Last -> RAM[0]=0x99, RAM[1] keeps its first-pass value, GPIO_OUT=0.
